// File: rtl/dtw_dispatch_arbiter.sv
// dtw_dispatch_arbiter
// Feeds a bank of DTW cores from one upstream stream and merges their
// 3-word results (qid, position, minval) onto one downstream stream.
// Load mode broadcasts the reference to every core; query mode hands each
// complete query (ID word + SQG_SIZE samples) to the next free core in
// round-robin order. A pending mask keeps a core out of rotation from the
// moment it is granted until its result has fully drained.

module dtw_dispatch_arbiter #(
    parameter int N_CORES    = 4,
    parameter int SQG_SIZE   = 250,
    parameter int AXIS_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          start,
    input  logic                          op_mode,
    input  logic [31:0]                   ref_len,
    output logic                          busy,
    output logic                          ref_loaded,

    input  logic [AXIS_WIDTH-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,

    output logic [AXIS_WIDTH-1:0]         core_src_data,
    output logic [N_CORES-1:0]            core_src_valid,
    input  logic [N_CORES-1:0]            core_src_ready,
    input  logic [N_CORES-1:0]            core_idle,

    input  logic [N_CORES*AXIS_WIDTH-1:0] core_res_data,
    input  logic [N_CORES-1:0]            core_res_valid,
    output logic [N_CORES-1:0]            core_res_ready,

    output logic [AXIS_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,

    output logic [31:0]                   dispatched
);

    localparam int GW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int unsigned NC = N_CORES;
    localparam logic [GW-1:0] LAST_CORE = GW'(N_CORES - 1);
    localparam logic [31:0] QUERY_LAST = 32'(SQG_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        REF_BCAST,
        PICK,
        STREAM,
        DONE
    } disp_state_t;

    typedef enum logic {
        C_IDLE,
        C_XFER
    } coll_state_t;

    // Dispatcher state
    disp_state_t        d_state;
    logic [31:0]        ref_len_r;
    logic [31:0]        word_cnt;
    logic [GW-1:0]      grant;
    logic [GW-1:0]      last_grant;

    // Collector state
    coll_state_t        c_state;
    logic [GW-1:0]      res_grant;
    logic [GW-1:0]      last_res;
    logic [1:0]         res_cnt;

    // Shared bookkeeping
    logic [N_CORES-1:0] pending;
    logic [N_CORES-1:0] pend_set;
    logic [N_CORES-1:0] pend_clr;

    // Round-robin search results
    logic [GW:0]        pick;
    logic               pick_found;
    logic [GW-1:0]      pick_idx;
    logic [GW:0]        res_pick;
    logic               res_found;
    logic [GW-1:0]      res_idx;

    logic               src_xfer;
    logic               res_xfer;

    // First requester found scanning upward from last+1, wrapping at N_CORES.
    // Result is {found, index}.
    function automatic logic [GW:0] rr_pick(input logic [N_CORES-1:0] req,
                                            input logic [GW-1:0]      last);
        logic [GW:0]  r;
        int unsigned  idx;
        r = '0;
        for (int unsigned k = 1; k <= NC; k++) begin
            idx = (32'(last) + k) % NC;
            if (!r[GW] && req[idx]) begin
                r = {1'b1, GW'(idx)};
            end
        end
        return r;
    endfunction

    // Arbitration for both directions is evaluated every cycle; each FSM
    // registers the winner only in its own decision state.
    always_comb begin
        pick     = rr_pick(core_idle & ~pending, last_grant);
        res_pick = rr_pick(core_res_valid, last_res);
    end

    assign pick_found = pick[GW];
    assign pick_idx   = pick[GW-1:0];
    assign res_found  = res_pick[GW];
    assign res_idx    = res_pick[GW-1:0];

    // Upstream words go straight through to every core; only the strobes differ.
    assign core_src_data = s_data;

    // Upstream handshake: all cores together in broadcast, one core in stream.
    always_comb begin
        s_ready        = 1'b0;
        core_src_valid = '0;
        case (d_state)
            REF_BCAST: begin
                // Gate once the count is reached so ref_len=0 takes no word.
                if (word_cnt != ref_len_r) begin
                    s_ready        = &core_src_ready;
                    core_src_valid = {N_CORES{s_valid}};
                end
            end
            STREAM: begin
                s_ready               = core_src_ready[grant];
                core_src_valid[grant] = s_valid;
            end
            default: ;
        endcase
    end

    assign src_xfer = s_valid & s_ready;

    // Dispatcher FSM: broadcast, pick a core, stream one query into it.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_state    <= IDLE;
            busy       <= 1'b0;
            ref_loaded <= 1'b0;
            ref_len_r  <= '0;
            word_cnt   <= '0;
            grant      <= '0;
            last_grant <= LAST_CORE;
            dispatched <= '0;
        end else begin
            case (d_state)
                IDLE: begin
                    if (start) begin
                        if (op_mode) begin
                            d_state   <= REF_BCAST;
                            busy      <= 1'b1;
                            ref_len_r <= ref_len;
                            word_cnt  <= '0;
                        end else if (ref_loaded) begin
                            d_state <= PICK;
                            busy    <= 1'b1;
                        end
                    end
                end
                REF_BCAST: begin
                    if (word_cnt == ref_len_r) begin
                        d_state    <= DONE;
                        ref_loaded <= 1'b1;
                    end else if (src_xfer) begin
                        word_cnt <= word_cnt + 32'd1;
                        // Leave on the final word so DONE follows it directly.
                        if (word_cnt + 32'd1 == ref_len_r) begin
                            d_state    <= DONE;
                            ref_loaded <= 1'b1;
                        end
                    end
                end
                PICK: begin
                    if (pick_found) begin
                        grant    <= pick_idx;
                        word_cnt <= '0;
                        d_state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (src_xfer) begin
                        if (word_cnt == QUERY_LAST) begin
                            word_cnt   <= '0;
                            dispatched <= dispatched + 32'd1;
                            last_grant <= grant;
                            d_state    <= PICK;
                        end else begin
                            word_cnt <= word_cnt + 32'd1;
                        end
                    end
                end
                DONE: begin
                    d_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    d_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Downstream mux: the latched core's slice and handshake, nothing else.
    always_comb begin
        m_data         = '0;
        m_valid        = 1'b0;
        m_last         = 1'b0;
        core_res_ready = '0;
        if (c_state == C_XFER) begin
            m_data                    = core_res_data[int'(res_grant)*AXIS_WIDTH +: AXIS_WIDTH];
            m_valid                   = core_res_valid[res_grant];
            core_res_ready[res_grant] = m_ready;
            m_last                    = (res_cnt == 2'd2) && core_res_valid[res_grant];
        end
    end

    assign res_xfer = m_valid & m_ready;

    // Collector FSM: lock onto one core for its three result words.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_state   <= C_IDLE;
            res_grant <= '0;
            last_res  <= LAST_CORE;
            res_cnt   <= '0;
        end else begin
            case (c_state)
                C_IDLE: begin
                    if (res_found) begin
                        res_grant <= res_idx;
                        res_cnt   <= '0;
                        c_state   <= C_XFER;
                    end
                end
                C_XFER: begin
                    if (res_xfer) begin
                        if (res_cnt == 2'd2) begin
                            last_res <= res_grant;
                            c_state  <= C_IDLE;
                        end else begin
                            res_cnt <= res_cnt + 2'd1;
                        end
                    end
                end
                default: c_state <= C_IDLE;
            endcase
        end
    end

    // Set on grant, clear when the result's last word leaves.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (d_state == PICK && pick_found) begin
            pend_set[pick_idx] = 1'b1;
        end
        if (c_state == C_XFER && res_xfer && res_cnt == 2'd2) begin
            pend_clr[res_grant] = 1'b1;
        end
    end

    // Pending mask update; a same-cycle set overrides the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

endmodule

// File: tb/tb_dtw_dispatch_arbiter.sv
// Bench for dtw_dispatch_arbiter: broadcast, gated query start, round-robin
// dispatch with backpressure, result arbitration and output stall.
// Upstream and result expectations are queued when stimulus is driven and
// popped by a monitor when the DUT moves the word.

module tb_dtw_dispatch_arbiter;

    localparam int N   = 4;
    localparam int SQG = 4;
    localparam int W   = 32;
    localparam int TMO = 200;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           op_mode;
    logic [31:0]    ref_len;
    logic           busy;
    logic           ref_loaded;
    logic [W-1:0]   s_data;
    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   core_src_data;
    logic [N-1:0]   core_src_valid;
    logic [N-1:0]   core_src_ready;
    logic [N-1:0]   core_idle;
    logic [N*W-1:0] core_res_data;
    logic [N-1:0]   core_res_valid;
    logic [N-1:0]   core_res_ready;
    logic [W-1:0]   m_data;
    logic           m_valid;
    logic           m_ready;
    logic           m_last;
    logic [31:0]    dispatched;

    always #5 clk = ~clk;

    dtw_dispatch_arbiter #(
        .N_CORES   (N),
        .SQG_SIZE  (SQG),
        .AXIS_WIDTH(W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .op_mode       (op_mode),
        .ref_len       (ref_len),
        .busy          (busy),
        .ref_loaded    (ref_loaded),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .core_src_data (core_src_data),
        .core_src_valid(core_src_valid),
        .core_src_ready(core_src_ready),
        .core_idle     (core_idle),
        .core_res_data (core_res_data),
        .core_res_valid(core_res_valid),
        .core_res_ready(core_res_ready),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .dispatched    (dispatched)
    );

    typedef struct packed {
        logic [N-1:0] mask;
        logic [W-1:0] data;
    } src_exp_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } m_exp_t;

    src_exp_t    sb_src[$];
    m_exp_t      sb_m[$];
    src_exp_t    mon_se;
    m_exp_t      mon_me;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Result words issued by the bench / consumed by the DUT, per core.
    int unsigned issued[N];
    int unsigned taken[N];
    logic [N-1:0] res_fire;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] res_word(input int unsigned c, input int unsigned k);
        return 32'hD000_0000 | (32'(c) << 12) | 32'(k);
    endfunction

    // Each core presents its next result word whenever it has one outstanding.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            core_res_valid[i]        = (issued[i] != taken[i]);
            core_res_data[i*W +: W]  = res_word(32'(i), taken[i]);
        end
    end

    // Advance a core's result word just after the edge that accepted it.
    always begin
        @(negedge clk);
        res_fire = core_res_valid & core_res_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (res_fire[i]) taken[i]++;
        end
    end

    // Monitor: compare every moved word (and every held output word).
    always @(negedge clk) begin
        if (!rst) begin
            if (s_valid && s_ready) begin
                if (sb_src.size() == 0) begin
                    check("src_unexpected", 32'(core_src_valid), 32'd0);
                end else begin
                    mon_se = sb_src.pop_front();
                    check("src_mask", 32'(core_src_valid), 32'(mon_se.mask));
                    check("src_data", core_src_data, mon_se.data);
                end
            end
            if (m_valid) begin
                if (sb_m.size() == 0) begin
                    check("m_unexpected", 32'(m_valid), 32'd0);
                end else begin
                    mon_me = sb_m[0];
                    check("m_data", m_data, mon_me.data);
                    check("m_last", 32'(m_last), 32'(mon_me.last));
                    if (m_ready) void'(sb_m.pop_front());
                end
            end else if (m_last) begin
                check("m_last_no_valid", 32'(m_last), 32'd0);
            end
        end
    end

    // Present one upstream word and wait (bounded) until it is accepted.
    task automatic send_word(input logic [W-1:0] d, input logic [N-1:0] mask,
                             input int unsigned stall);
        int unsigned n;
        @(posedge clk);
        #1;
        s_data  = d;
        s_valid = 1'b1;
        sb_src.push_back('{mask: mask, data: d});
        if (stall != 0) begin
            core_src_ready = ~mask;
            for (int unsigned i = 0; i < stall; i++) begin
                @(negedge clk);
                check("bp_s_ready", 32'(s_ready), 32'd0);
            end
            @(posedge clk);
            #1;
            core_src_ready = '1;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > TMO) begin
                check("src_timeout", 32'(s_ready), 32'd1);
                break;
            end
        end
    endtask

    task automatic send_query(input int unsigned q, input int unsigned core,
                              input int unsigned stall);
        for (int unsigned w = 0; w <= SQG; w++) begin
            send_word(32'h5100_0000 + (q << 8) + w, N'(32'd1 << core),
                      (w == 2) ? stall : 0);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Queue the three expected output words for core c and release them.
    task automatic issue_result(input int unsigned c);
        for (int unsigned k = 0; k < 3; k++) begin
            sb_m.push_back('{data: res_word(c, issued[c] + k), last: (k == 2)});
        end
        issued[c] += 3;
    endtask

    task automatic pulse_start(input logic mode, input logic [31:0] len);
        @(posedge clk);
        #1;
        start   = 1'b1;
        op_mode = mode;
        ref_len = len;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        rst            = 1'b1;
        start          = 1'b0;
        op_mode        = 1'b0;
        ref_len        = '0;
        s_data         = '0;
        s_valid        = 1'b0;
        core_src_ready = '1;
        core_idle      = '1;
        m_ready        = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",       32'(busy),           32'd0);
        check("rst_ref_loaded", 32'(ref_loaded),     32'd0);
        check("rst_s_ready",    32'(s_ready),        32'd0);
        check("rst_m_valid",    32'(m_valid),        32'd0);
        check("rst_m_last",     32'(m_last),         32'd0);
        check("rst_src_valid",  32'(core_src_valid), 32'd0);
        check("rst_res_ready",  32'(core_res_ready), 32'd0);
        check("rst_dispatched", dispatched,          32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Query start before any reference: ignored.
        pulse_start(1'b0, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("noload_busy", 32'(busy), 32'd0);
        end

        // Reference broadcast of 5 words.
        pulse_start(1'b1, 32'd5);
        @(negedge clk);
        check("bcast_busy", 32'(busy), 32'd1);
        for (int unsigned i = 0; i < 5; i++) begin
            send_word(32'hB000_0000 + i, '1, 0);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("bcast_busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("bcast_busy_fall", 32'(busy), 32'd0);
        check("bcast_loaded",    32'(ref_loaded), 32'd1);

        // Query mode: four queries rotate over cores 0..3, core 1 stalled.
        pulse_start(1'b0, 32'd0);
        send_query(0, 0, 0);
        send_query(1, 1, 10);
        send_query(2, 2, 0);
        send_query(3, 3, 0);

        // Fifth query waits for core 0's result, drained with an output stall.
        fork
            send_query(4, 0, 0);
            begin
                repeat (5) @(negedge clk);
                check("wait_s_ready",    32'(s_ready),        32'd0);
                check("wait_src_valid",  32'(core_src_valid), 32'd0);
                check("wait_dispatched", dispatched,          32'd4);
                check("wait_busy",       32'(busy),           32'd1);
                @(posedge clk);
                #1;
                issue_result(0);
                n = 0;
                forever begin
                    @(negedge clk);
                    if (m_valid && m_ready) break;
                    n++;
                    if (n > TMO) begin
                        check("m_timeout", 32'(m_valid), 32'd1);
                        break;
                    end
                end
                @(posedge clk);
                #1;
                m_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_m_valid", 32'(m_valid), 32'd1);
                    check("stall_m_last",  32'(m_last),  32'd0);
                end
                @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        check("dispatched_5", dispatched, 32'd5);

        // Cores 2 and 0 report together; core 2 follows core 0 in rotation.
        @(posedge clk);
        #1;
        issue_result(2);
        issue_result(0);

        n = 0;
        while (sb_m.size() != 0 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("m_drain",   32'(sb_m.size()),   32'd0);
        check("src_drain", 32'(sb_src.size()), 32'd0);
        check("final_dispatched", dispatched, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
